// File: rtl/lif_array.sv
// Bank of CHANNELS leaky integrate-and-fire neurons with per-channel refractory hold.
// Define LIF_ARRAY_RESET_SUBTRACT_EN to keep the residual (sum - THRESHOLD) after a spike.
module lif_array #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACTORY = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] current,
    output logic [CHANNELS*WIDTH-1:0] state,
    output logic [CHANNELS-1:0]       spk,
    output logic [CHANNELS-1:0]       refr,
    output logic                      spk_any
);

    localparam int               CW       = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [WIDTH-1:0] THR      = WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]    REF_LOAD = CW'(REFRACTORY);
    localparam logic [WIDTH-1:0] SAT_MAX  = '1;

    generate
        if (CHANNELS < 1 || WIDTH < 2 || WIDTH > 30 ||
            THRESHOLD < 1 || THRESHOLD > (2 ** WIDTH) - 1 ||
            LEAK_SHIFT < 1 || LEAK_SHIFT > WIDTH - 1 ||
            REFRACTORY < 0 || REFRACTORY > 255) begin : g_param_err
            $error("lif_array: parameter out of range");
        end
    endgenerate

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] r_state;
        logic [CW-1:0]    r_cnt;
        logic             r_spk;
        logic [WIDTH-1:0] w_cur;
        logic [WIDTH-1:0] w_leak;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH-1:0] w_sat;
        logic [WIDTH-1:0] w_post;
        logic             w_fire;

        assign w_cur  = current[i*WIDTH +: WIDTH];
        assign w_leak = r_state >> LEAK_SHIFT;
        // One extra bit catches the carry so the sum clamps instead of wrapping.
        assign w_sum  = {1'b0, w_cur} + {1'b0, w_leak};
        assign w_sat  = w_sum[WIDTH] ? SAT_MAX : w_sum[WIDTH-1:0];
        assign w_fire = (w_sat >= THR);
`ifdef LIF_ARRAY_RESET_SUBTRACT_EN
        assign w_post = w_sat - THR;
`else
        assign w_post = '0;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= '0;
                r_cnt   <= '0;
                r_spk   <= 1'b0;
            end else if (en) begin
                if (r_cnt != '0) begin
                    r_state <= w_leak;
                    r_cnt   <= r_cnt - CW'(1);
                    r_spk   <= 1'b0;
                end else if (w_fire) begin
                    r_state <= w_post;
                    r_cnt   <= REF_LOAD;
                    r_spk   <= 1'b1;
                end else begin
                    r_state <= w_sat;
                    r_spk   <= 1'b0;
                end
            end else begin
                r_spk <= 1'b0;
            end
        end

        assign state[i*WIDTH +: WIDTH] = r_state;
        assign spk[i]                  = r_spk;
        assign refr[i]                 = (r_cnt != '0);
    end

    assign spk_any = |spk;

endmodule

// File: tb/tb_lif_array.sv
// Bench for lif_array: three instances (default, THRESHOLD=255, REFRACTORY=0) checked each cycle
// against an integer model, plus hand-computed expectations for the documented scenarios.
module tb_lif_array;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] cur   [3];
    logic [31:0] st_o  [3];
    logic [3:0]  spk_o [3];
    logic [3:0]  refr_o[3];
    logic        any_o [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    lif_array u_dut0 (.clk(clk), .reset(reset), .en(en), .current(cur[0]),
                      .state(st_o[0]), .spk(spk_o[0]), .refr(refr_o[0]), .spk_any(any_o[0]));
    lif_array #(.THRESHOLD(255)) u_dut1 (.clk(clk), .reset(reset), .en(en), .current(cur[1]),
                      .state(st_o[1]), .spk(spk_o[1]), .refr(refr_o[1]), .spk_any(any_o[1]));
    lif_array #(.THRESHOLD(100), .REFRACTORY(0)) u_dut2 (.clk(clk), .reset(reset), .en(en),
                      .current(cur[2]), .state(st_o[2]), .spk(spk_o[2]), .refr(refr_o[2]),
                      .spk_any(any_o[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: plain integer arithmetic per instance/channel.
    int m_thr[3] = '{200, 255, 100};
    int m_ref[3] = '{3, 3, 0};
    int m_st [3][4];
    int m_cnt[3][4];
    int m_spk[3][4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 4; i++) begin
                    m_st[k][i] = 0; m_cnt[k][i] = 0; m_spk[k][i] = 0;
                end
        end else begin
            for (int k = 0; k < 3; k++)
                for (int i = 0; i < 4; i++) begin
                    int sum;
                    if (!en) begin
                        m_spk[k][i] = 0;
                    end else if (m_cnt[k][i] > 0) begin
                        m_st[k][i]  = m_st[k][i] / 2;
                        m_cnt[k][i] = m_cnt[k][i] - 1;
                        m_spk[k][i] = 0;
                    end else begin
                        sum = int'(cur[k][i*8 +: 8]) + m_st[k][i] / 2;
                        if (sum > 255) sum = 255;
                        if (sum >= m_thr[k]) begin
                            m_spk[k][i] = 1;
                            m_cnt[k][i] = m_ref[k];
`ifdef LIF_ARRAY_RESET_SUBTRACT_EN
                            m_st[k][i]  = sum - m_thr[k];
`else
                            m_st[k][i]  = 0;
`endif
                        end else begin
                            m_st[k][i]  = sum;
                            m_spk[k][i] = 0;
                        end
                    end
                end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                int any_exp;
                any_exp = 0;
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("d%0d.state%0d", k, i), int'(st_o[k][i*8 +: 8]), m_st[k][i]);
                    chk($sformatf("d%0d.spk%0d", k, i), int'(spk_o[k][i]), m_spk[k][i]);
                    chk($sformatf("d%0d.refr%0d", k, i), int'(refr_o[k][i]),
                        (m_cnt[k][i] != 0) ? 1 : 0);
                    if (m_spk[k][i] != 0) any_exp = 1;
                end
                chk($sformatf("d%0d.spk_any", k), int'(any_o[k]), any_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ch0_tab[8] = '{60, 90, 105, 112, 116, 118, 119, 119};
`ifdef LIF_ARRAY_RESET_SUBTRACT_EN
    int ch1_st[6]  = '{150, 25, 12, 6, 3, 151};
`else
    int ch1_st[6]  = '{150, 0, 0, 0, 0, 150};
`endif
    int ch1_spk[6] = '{0, 1, 0, 0, 0, 0};
    int ch1_ref[6] = '{0, 1, 1, 1, 0, 0};
    int d1_st[2]   = '{200, 0};
    int d1_spk[2]  = '{0, 1};

    initial begin
        reset = 1;
        en    = 0;
        for (int k = 0; k < 3; k++) cur[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 0;
        chk_en = 1;
        chk("reset.state", int'(st_o[0]), 0);
        chk("reset.refr", int'(refr_o[0]), 0);

        // ch0=60 leaky climb, ch1=150 spike/refractory, saturation at THRESHOLD=255,
        // and back-to-back spikes with no refractory.
        cur[0] = {8'd0, 8'd0, 8'd150, 8'd60};
        cur[1] = {8'd0, 8'd200, 8'd0, 8'd0};
        cur[2] = {24'd0, 8'd100};
        en     = 1;
        for (int s = 0; s < 8; s++) begin
            tick();
            chk($sformatf("t2.ch0_state[%0d]", s), int'(st_o[0][7:0]), ch0_tab[s]);
            chk($sformatf("t2.ch0_spk[%0d]", s), int'(spk_o[0][0]), 0);
            if (s < 6) begin
                chk($sformatf("t3.ch1_state[%0d]", s), int'(st_o[0][15:8]), ch1_st[s]);
                chk($sformatf("t3.ch1_spk[%0d]", s), int'(spk_o[0][1]), ch1_spk[s]);
                chk($sformatf("t3.ch1_refr[%0d]", s), int'(refr_o[0][1]), ch1_ref[s]);
            end
            if (s < 2) begin
                chk($sformatf("t4.ch2_state[%0d]", s), int'(st_o[1][23:16]), d1_st[s]);
                chk($sformatf("t4.ch2_spk[%0d]", s), int'(spk_o[1][2]), d1_spk[s]);
            end
            if (s < 4) chk($sformatf("r0.spk[%0d]", s), int'(spk_o[2][0]), 1);
        end

        // Reset mid-run while ch1 is refractory (spiked on step 7): immediate clear.
        chk("t6.pre_refr", int'(refr_o[0][1]), 1);
        reset = 1;
        #1;
        chk("t1.state", int'(st_o[0]), 0);
        chk("t1.spk", int'(spk_o[0]), 0);
        chk("t1.refr", int'(refr_o[0]), 0);
        chk("t1.spk_any", int'(any_o[0]), 0);
        reset = 0;
        tick();
        chk("t6.ch1_state", int'(st_o[0][15:8]), 150);
        chk("t6.ch1_refr", int'(refr_o[0][1]), 0);

        // en pattern 1,0,0,1,0 with only ch3 driven.
        en = 0;
        cur[0] = {8'd150, 24'd0};
        reset = 1;
        #1;
        reset = 0;
        en = 1; tick();
        chk("t5.s1_state", int'(st_o[0][31:24]), 150);
        en = 0; tick();
        chk("t5.hold1_state", int'(st_o[0][31:24]), 150);
        en = 0; tick();
        chk("t5.hold2_state", int'(st_o[0][31:24]), 150);
        chk("t5.hold2_spk", int'(spk_o[0][3]), 0);
        en = 1; tick();
        chk("t5.fire_spk", int'(spk_o[0][3]), 1);
        chk("t5.fire_any", int'(any_o[0]), 1);
        chk("t5.fire_state", int'(st_o[0][31:24]), 0);
        en = 0; tick();
        chk("t5.after_spk", int'(spk_o[0][3]), 0);
        chk("t5.after_any", int'(any_o[0]), 0);
        chk("t5.after_refr", int'(refr_o[0][3]), 1);
        chk("t5.others", int'(st_o[0][23:0]), 0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
